// File: rtl/data_sram_responder.sv
// Memory-side responder for the data_sram req/addr_ok + data_ok/rdata bus.
// Ports: clk, resetn, data_sram_{req,wr,size,addr,wstrb,wdata} in; data_sram_{addr_ok,data_ok,rdata} out.
module data_sram_responder #(
  parameter int          ADDR_W          = 10,
  parameter int          LATENCY         = 2,
  parameter int          DEPTH           = 4,
  parameter logic [7:0]  ADDR_OK_PATTERN = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(LATENCY + 1);

  logic [31:0]   r_mem [0:(1<<ADDR_W)-1];
  logic [7:0]    r_pat;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          r_q_wr  [DEPTH];
  logic [31:0]   r_q_dat [DEPTH];
  logic [AW-1:0] r_age   [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rword;
  logic [31:0]       w_merge;
  logic              w_addr_ok;
  logic              w_data_ok;
  logic              w_acc;
  logic              w_unused_ok;

  // Size, byte offset and high address bits do not select storage.
  assign w_unused_ok = ^{data_sram_size,
                         data_sram_addr[1:0],
                         data_sram_addr[31:ADDR_W+2]};

  assign w_idx   = data_sram_addr[ADDR_W+1:2];
  assign w_rword = r_mem[w_idx];

  always_comb begin
    w_merge = w_rword;
    for (int b = 0; b < 4; b++) begin
      if (data_sram_wstrb[b]) begin
        w_merge[8*b +: 8] = data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Registered count only: a pop in this cycle does not free a slot.
  assign w_addr_ok = r_pat[7] && (r_cnt < CW'(DEPTH));
  assign w_acc     = data_sram_req && w_addr_ok;
  assign w_data_ok = (r_cnt != '0) &&
                     (r_age[r_rp] >= AW'(LATENCY - 1));

  assign data_sram_addr_ok = w_addr_ok;
  assign data_sram_data_ok = w_data_ok;
  assign data_sram_rdata   = (w_data_ok && !r_q_wr[r_rp])
                           ? r_q_dat[r_rp] : 32'h0;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pat <= ADDR_OK_PATTERN;
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      r_pat <= {r_pat[6:0], r_pat[7]};
      if (w_acc) r_wp <= f_inc(r_wp);
      if (w_data_ok) r_rp <= f_inc(r_rp);
      if (w_acc && !w_data_ok) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_acc && w_data_ok) begin
        r_cnt <= r_cnt - 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_acc && (r_wp == PW'(i))) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AW'(LATENCY)) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  // Storage and queue payload carry no reset; count gates their use.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_q_wr[r_wp]  <= data_sram_wr;
      r_q_dat[r_wp] <= w_rword;
      if (data_sram_wr) r_mem[w_idx] <= w_merge;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
// Five instances cover the latency, depth and addr_ok pattern variants.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [4:0]  aok;
  logic [4:0]  dok;
  logic [31:0] rdat [5];

  int checks = 0;
  int errors = 0;
  int acc_cyc [8];
  int rsp_cyc [8];

  always #5 clk = ~clk;

  data_sram_responder #(.LATENCY(2), .DEPTH(4)) u0 (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[0]),
    .data_sram_data_ok(dok[0]), .data_sram_rdata(rdat[0]));
  data_sram_responder #(.LATENCY(3), .DEPTH(4)) u1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[1]),
    .data_sram_data_ok(dok[1]), .data_sram_rdata(rdat[1]));
  data_sram_responder #(.LATENCY(1), .DEPTH(4)) u2 (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[2]),
    .data_sram_data_ok(dok[2]), .data_sram_rdata(rdat[2]));
  data_sram_responder #(.LATENCY(2), .DEPTH(4),
                        .ADDR_OK_PATTERN(8'hAA)) u3 (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[3]),
    .data_sram_data_ok(dok[3]), .data_sram_rdata(rdat[3]));
  data_sram_responder #(.LATENCY(3), .DEPTH(2)) u4 (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[4]),
    .data_sram_data_ok(dok[4]), .data_sram_rdata(rdat[4]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request, then wait out its latency and check the response.
  task automatic single(input int idx, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input int lat, input logic [31:0] exp);
    int n;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    n = 0;
    while (!aok[idx] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aok_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int c = 1; c < lat; c++) begin
      chk("dok_early", 32'(dok[idx]), 32'd0);
      @(negedge clk);
    end
    chk("dok_on_time", 32'(dok[idx]), 32'd1);
    chk("rdata", rdat[idx], exp);
    @(negedge clk);
    chk("dok_after", 32'(dok[idx]), 32'd0);
  endtask

  // req held high across n requests; records accept/response cycles.
  task automatic burst(input int idx, input logic w, input int n,
                       input logic [31:0] ab, input logic [31:0] db,
                       input bit tgl);
    int na;
    int nr;
    logic acc;
    logic prev;
    na = 0; nr = 0; prev = 1'b0;
    req = 1'b1; wr = w; wstrb = 4'hF; addr = ab; wdata = db;
    for (int c = 0; c < 60 && nr < n; c++) begin
      acc = req && aok[idx];
      if (tgl && c > 0) chk("aok_toggle", 32'(aok[idx] != prev), 32'd1);
      prev = aok[idx];
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        acc_cyc[na] = c;
        na++;
        if (na < n) begin
          addr  = ab + 32'(4 * na);
          wdata = db + 32'(na);
        end else begin
          req = 1'b0;
        end
      end
      if (dok[idx]) begin
        rsp_cyc[nr] = c;
        chk("burst_rdata", rdat[idx], w ? 32'h0 : db + 32'(nr));
        nr++;
      end
    end
    chk("burst_count", 32'(nr), 32'(n));
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    resetn = 1'b0;
    req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int ea [5];
    int er [5];
    resetn = 1'b0; req = 1'b0; wr = 1'b0;
    addr = '0; wstrb = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_dok", 32'(dok), 32'd0);
    chk("rst_rdata0", rdat[0], 32'h0);
    chk("rst_rdata4", rdat[4], 32'h0);
    chk("rst_aok0", 32'(aok[0]), 32'd1);
    resetn = 1'b1;

    // Full write then read back, latency 2
    single(0, 1'b1, 32'h10, 4'hF, 32'h12345678, 2, 32'h0);
    single(0, 1'b0, 32'h10, 4'h0, 32'h0, 2, 32'h12345678);

    // Byte strobes and upper-address aliasing
    single(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 2, 32'h0);
    single(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 2, 32'h0);
    single(0, 1'b0, 32'h20, 4'h0, 32'h0, 2, 32'h11BB33DD);
    single(0, 1'b0, 32'h20 + (32'd4 << 10), 4'h0, 32'h0, 2, 32'h11BB33DD);
    single(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 2, 32'h0);
    single(0, 1'b0, 32'h22, 4'h0, 32'h0, 2, 32'h11BB33DD);

    // Preload reads for the back-to-back bursts
    for (int i = 0; i < 5; i++) begin
      single(1, 1'b1, 32'h100 + 32'(4 * i), 4'hF,
             32'hC0DE0000 + 32'(i), 3, 32'h0);
    end

    // LATENCY=3, DEPTH=4: no stall, back-to-back responses
    rst_pulse();
    burst(1, 1'b0, 5, 32'h100, 32'hC0DE0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("d4_acc", 32'(acc_cyc[i]), 32'(i));
      chk("d4_rsp", 32'(rsp_cyc[i]), 32'(i + 2));
    end

    // LATENCY=3, DEPTH=2: addr_ok drops when full, pop frees next cycle
    rst_pulse();
    burst(4, 1'b0, 5, 32'h100, 32'hC0DE0000, 1'b0);
    ea = '{0, 1, 4, 5, 8};
    er = '{2, 3, 6, 7, 10};
    for (int i = 0; i < 5; i++) begin
      chk("d2_acc", 32'(acc_cyc[i]), 32'(ea[i]));
      chk("d2_rsp", 32'(rsp_cyc[i]), 32'(er[i]));
    end

    // Alternating addr_ok pattern with req held high
    rst_pulse();
    burst(3, 1'b1, 4, 32'h200, 32'h5A000000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("aa_wr_gap", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd2);
    end
    burst(3, 1'b0, 4, 32'h200, 32'h5A000000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("aa_rd_lat", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
    end

    // LATENCY=1: read right after write to the same word
    rst_pulse();
    req = 1'b1; wr = 1'b1; addr = 32'h30; wstrb = 4'hF; wdata = 32'hCAFEF00D;
    chk("l1_aok", 32'(aok[2]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("l1_wr_dok", 32'(dok[2]), 32'd1);
    chk("l1_wr_rdata", rdat[2], 32'h0);
    chk("l1_aok2", 32'(aok[2]), 32'd1);
    wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("l1_rd_dok", 32'(dok[2]), 32'd1);
    chk("l1_rd_rdata", rdat[2], 32'hCAFEF00D);
    @(negedge clk);
    chk("l1_idle", 32'(dok[2]), 32'd0);

    // Reset in the middle of outstanding traffic
    rst_pulse();
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_pre_dok", 32'(dok[0]), 32'd1);
    chk("mid_pre_rdata", rdat[0], 32'h12345678);
    resetn = 1'b0;
    #1;
    chk("mid_rst_dok", 32'(dok[0]), 32'd0);
    chk("mid_rst_rdata", rdat[0], 32'h0);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mid_no_dok", 32'(dok[0]), 32'd0);
      chk("mid_aok", 32'(aok[0]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
